// File: rtl/result_drain_if.sv
// Result stream from result_drain to its consumer: one 2W-bit element per handshake.
// res_idx carries the matrix index k = row*N+col of the element on res_dat.
interface result_drain_if #(
  parameter int W = 32,
  parameter int N = 3
);
  localparam int IW = (N * N > 1) ? $clog2(N * N) : 1;

  logic          res_vld;
  logic          res_rdy;
  logic [2*W-1:0] res_dat;
  logic [IW-1:0] res_idx;
  logic          res_last;

  modport master (output res_vld, res_dat, res_idx, res_last, input res_rdy);
  modport slave  (input res_vld, res_dat, res_idx, res_last, output res_rdy);
endinterface

// File: rtl/result_drain.sv
// Snapshots the systolic array result LAT cycles after i_start and streams it out; RESULT_DRAIN_TRANSPOSE_EN selects column-major order.
// Latency: first element valid LAT+1 cycles after i_start; o_done one cycle after the last handshake.
// Backpressure: res_rdy low holds the current element stable; the snapshot is immune to later i_C changes.
module result_drain #(
  parameter int W   = 32,
  parameter int N   = 3,
  parameter int LAT = 7
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [2*W*N*N-1:0] i_C,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err,
  result_drain_if.master     res
);
  localparam int EW = 2 * W;
  localparam int NN = N * N;
  localparam int IW = (NN > 1) ? $clog2(NN) : 1;
  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  localparam logic [RW-1:0] N_M1   = RW'(N - 1);
  localparam logic [CW-1:0] LAT_M1 = CW'(LAT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    lat_cnt;
  logic [RW-1:0]    major;
  logic [RW-1:0]    minor;
  logic [EW*NN-1:0] snap;

  logic          drain;
  logic          hs;
  logic          last;
  logic [RW-1:0] row_c;
  logic [RW-1:0] col_c;
  logic [IW-1:0] k_idx;
  logic [EW-1:0] elem;

  // The drain pointer is split into a fast (minor) and slow (major) counter;
  // the build option only decides which of them walks the columns.
`ifdef RESULT_DRAIN_TRANSPOSE_EN
  assign row_c = minor;
  assign col_c = major;
`else
  assign row_c = major;
  assign col_c = minor;
`endif

  assign k_idx  = IW'(row_c * N + col_c);
  assign drain  = (state == ST_DRAIN);
  assign last   = drain && (major == N_M1) && (minor == N_M1);
  assign hs     = drain && res.res_rdy;
  assign o_busy = (state != ST_IDLE);

  always_comb begin
    elem = '0;
    for (int i = 0; i < NN; i++) begin
      if (k_idx == IW'(i)) elem = snap[i*EW +: EW];
    end
  end

  assign res.res_vld  = drain;
  assign res.res_dat  = drain ? elem : '0;
  assign res.res_idx  = drain ? k_idx : '0;
  assign res.res_last = last;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      lat_cnt <= '0;
      major   <= '0;
      minor   <= '0;
      snap    <= '0;
      o_done  <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_err  <= i_start && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            state   <= ST_WAIT;
            lat_cnt <= '0;
          end
        end
        ST_WAIT: begin
          // lat_cnt reads c-1 in cycle c, so capture happens at the end of cycle LAT
          if (lat_cnt == LAT_M1) begin
            snap  <= i_C;
            state <= ST_DRAIN;
            major <= '0;
            minor <= '0;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (hs) begin
            if (last) begin
              state  <= ST_IDLE;
              o_done <= 1'b1;
            end else if (minor == N_M1) begin
              minor <= '0;
              major <= major + 1'b1;
            end else begin
              minor <= minor + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
